// File: rtl/door_controller.sv
// Elevator cabin door controller: open/dwell/close sequencing with reopen,
// overload alarm and an opening counter. All outputs come straight from flops.
module door_controller #(
  parameter int unsigned OPEN_CYCLES = 8,
  parameter int unsigned MOVE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       complete,
  input  logic       over_weight,
  input  logic [2:0] out_floor,
  input  logic [1:0] direction,
  input  logic       door_btn_open,
  input  logic       door_btn_close,
  input  logic       obstruction,
  output logic [1:0] door_motor,
  output logic       door_open,
  output logic       hold,
  output logic       weight_alarm,
  output logic [2:0] door_floor,
  output logic [7:0] open_count
);

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    OPENING = 3'd1,
    OPEN    = 3'd2,
    CLOSING = 3'd3,
    ALARM   = 3'd4
  } state_e;

  localparam logic [1:0] MOTOR_STOP  = 2'd0;
  localparam logic [1:0] MOTOR_OPEN  = 2'd1;
  localparam logic [1:0] MOTOR_CLOSE = 2'd2;
  localparam logic [1:0] DIR_IDLE    = 2'd0;
  localparam logic [7:0] MOVE_LAST   = 8'(MOVE_CYCLES - 1);
  localparam logic [7:0] DWELL_LOAD  = 8'(OPEN_CYCLES);

  state_e     state_q, state_d;
  logic [7:0] phase_q, phase_d;
  logic [7:0] dwell_q, dwell_d;
  logic [2:0] floor_q, floor_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [1:0] motor_q, motor_d;
  logic       open_q,  open_d;
  logic       hold_q,  hold_d;
  logic       alarm_q, alarm_d;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dwell_d = dwell_q;
    floor_d = floor_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLOSED: begin
        // A simultaneous complete and open button still yields one transition.
        if (complete || (door_btn_open && direction == DIR_IDLE)) begin
          state_d = OPENING;
          phase_d = 8'd0;
          floor_d = out_floor;
        end
      end
      OPENING: begin
        if (phase_q == MOVE_LAST) begin
          state_d = OPEN;
          phase_d = 8'd0;
          dwell_d = DWELL_LOAD;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      OPEN: begin
        if (dwell_q != 8'd0) dwell_d = dwell_q - 8'd1;
        if (over_weight) begin
          state_d = ALARM;
        end else if (door_btn_open || complete) begin
          dwell_d = DWELL_LOAD;
        end else if (door_btn_close || dwell_q <= 8'd1) begin
          state_d = CLOSING;
          phase_d = 8'd0;
          dwell_d = 8'd0;
        end
      end
      CLOSING: begin
        // Reopen keeps the latched floor; the count bumps again on full open.
        if (obstruction || door_btn_open || over_weight) begin
          state_d = OPENING;
          phase_d = 8'd0;
        end else if (phase_q == MOVE_LAST) begin
          state_d = CLOSED;
          phase_d = 8'd0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      ALARM: begin
        if (door_btn_close && !over_weight) begin
          state_d = OPEN;
          dwell_d = DWELL_LOAD;
        end
      end
      default: begin
        state_d = CLOSED;
        phase_d = 8'd0;
        dwell_d = 8'd0;
      end
    endcase
  end

  // Output flops are loaded from the next-state decode so they track state_q.
  always_comb begin
    motor_d = MOTOR_STOP;
    open_d  = 1'b0;
    hold_d  = 1'b1;
    alarm_d = 1'b0;
    unique case (state_d)
      CLOSED:  hold_d  = 1'b0;
      OPENING: motor_d = MOTOR_OPEN;
      OPEN:    open_d  = 1'b1;
      CLOSING: motor_d = MOTOR_CLOSE;
      ALARM: begin
        open_d  = 1'b1;
        alarm_d = 1'b1;
      end
      default: hold_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLOSED;
      phase_q <= 8'd0;
      dwell_q <= 8'd0;
      floor_q <= 3'd1;
      cnt_q   <= 8'd0;
      motor_q <= MOTOR_STOP;
      open_q  <= 1'b0;
      hold_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      floor_q <= floor_d;
      cnt_q   <= cnt_d;
      motor_q <= motor_d;
      open_q  <= open_d;
      hold_q  <= hold_d;
      alarm_q <= alarm_d;
    end
  end

  assign door_motor   = motor_q;
  assign door_open    = open_q;
  assign hold         = hold_q;
  assign weight_alarm = alarm_q;
  assign door_floor   = floor_q;
  assign open_count   = cnt_q;

endmodule

// File: doc/door_controller.md
DOOR_CONTROLLER -- requirements
Module: door_controller

Interface
REQ-001 SHALL provide parameter OPEN_CYCLES, default 8, door dwell time in clk cycles, legal range 1..255.
REQ-002 SHALL provide parameter MOVE_CYCLES, default 4, door opening or closing travel time in clk cycles, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port complete, input, 1 bit: arrival/stop pulse from the car scheduling algorithm.
REQ-006 SHALL have port over_weight, input, 1 bit: overload flag from the scheduling algorithm.
REQ-007 SHALL have port out_floor, input, 3 bits: current car floor.
REQ-008 SHALL have port direction, input, 2 bits: 0 idle, 1 up, 2 down.
REQ-009 SHALL have port door_btn_open, input, 1 bit: cabin open button, level.
REQ-010 SHALL have port door_btn_close, input, 1 bit: cabin close button, level.
REQ-011 SHALL have port obstruction, input, 1 bit: door-edge sensor, level.
REQ-012 SHALL have port door_motor, output, 2 bits: 0 stop, 1 opening, 2 closing.
REQ-013 SHALL have port door_open, output, 1 bit: door fully open.
REQ-014 SHALL have port hold, output, 1 bit: stall request to the car motion stage.
REQ-015 SHALL have port weight_alarm, output, 1 bit: overload alarm.
REQ-016 SHALL have port door_floor, output, 3 bits: floor of the last door cycle.
REQ-017 SHALL have port open_count, output, 8 bits: count of completed door openings.

Function
REQ-018 SHALL implement FSM states CLOSED, OPENING, OPEN, CLOSING and ALARM, with all outputs registered.
REQ-019 In CLOSED, SHALL enter OPENING when complete=1, or when door_btn_open=1 and direction=0; on that edge SHALL latch door_floor <= out_floor.
REQ-020 In OPENING, SHALL drive door_motor=1 and advance an 8-bit phase counter, entering OPEN after exactly MOVE_CYCLES cycles.
REQ-021 On the OPENING->OPEN edge, SHALL increment open_count mod 256 (255 wraps to 0) and load the dwell counter with OPEN_CYCLES.
REQ-022 In OPEN, SHALL drive door_open=1 and door_motor=0, and decrement the dwell counter each cycle.
REQ-023 In OPEN, SHALL evaluate events in this priority: over_weight -> ALARM; door_btn_open or complete -> reload dwell with OPEN_CYCLES; door_btn_close -> CLOSING next cycle; dwell reaches 0 -> CLOSING.
REQ-024 In CLOSING, SHALL drive door_motor=2 and enter CLOSED after exactly MOVE_CYCLES cycles.
REQ-025 In CLOSING, SHALL return to OPENING with the phase counter cleared when obstruction, door_btn_open or over_weight is 1; obstruction takes priority.
REQ-026 A re-open from CLOSING SHALL NOT relatch door_floor; open_count SHALL still increment on the subsequent OPENING->OPEN edge.
REQ-027 In ALARM, SHALL drive door_open=1, weight_alarm=1 and door_motor=0; weight_alarm SHALL be 0 in every other state.
REQ-028 SHALL leave ALARM only when door_btn_close=1 and over_weight=0 on the same cycle, going to OPEN with dwell reloaded.
REQ-029 SHALL drive hold=1 in every state except CLOSED; hold SHALL be 1 on the same edge that CLOSED->OPENING is taken.
REQ-030 SHALL ignore complete, door_btn_close and obstruction while in OPENING, and door_btn_close while in CLOSED.
REQ-031 When complete=1 and door_btn_open=1 arrive together in CLOSED, SHALL take a single transition to OPENING.

Reset
REQ-032 On rst=1 at a clock edge, SHALL enter CLOSED regardless of current state, including mid-OPENING, mid-CLOSING and ALARM.
REQ-033 Reset values SHALL be: door_motor=0, door_open=0, hold=0, weight_alarm=0, door_floor=1, open_count=0, and both counters 0.
REQ-034 rst SHALL take priority over every other input on the same edge.

Verification
REQ-035 Bench SHALL cover: reset, then a 1-cycle complete pulse with out_floor=5 -> hold=1 next cycle; door_motor=1 for 4 cycles; door_open=1 for 8 cycles; door_motor=2 for 4 cycles; then CLOSED with hold=0, door_floor=5, open_count=1.
REQ-036 Bench SHALL cover: obstruction=1 on the 2nd CLOSING cycle -> door_motor=1 on the next cycle, a full 4-cycle reopen, open_count=2, door_floor unchanged.
REQ-037 Bench SHALL cover: over_weight=1 during OPEN -> weight_alarm=1 and door_open held; door_btn_close with over_weight=1 has no effect; door_btn_close with over_weight=0 -> OPEN with 8-cycle dwell, weight_alarm=0.
REQ-038 Bench SHALL cover: door_btn_open held during OPEN for 20 cycles -> door_open stays 1 throughout, and closing starts 8 cycles after release.
REQ-039 Bench SHALL cover: 256 complete door cycles -> open_count wraps to 0.
REQ-040 Bench SHALL cover: rst=1 on the 3rd OPENING cycle -> next cycle all outputs at reset values, door_floor=1.
